// File: rtl/thor2022_pte_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : thor2022_pte_writeback
//  Description : Page-table-entry write-back queue. Buffers modified 256-bit
//                PTEs evicted from the TLB and writes each one to memory as
//                two 128-bit classic-Wishbone write beats (low half first).
//                A pending entry with the same 32-byte line address is
//                updated in place instead of taking a new slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module thor2022_pte_writeback #(
    parameter int DEPTH = 4,
    parameter int AWID  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    output logic            rdy_o,
    input  logic [AWID-1:0] adr_i,
    input  logic [255:0]    pte_i,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [15:0]     sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [127:0]    dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    output logic            busy_o,
    output logic [4:0]      count_o,
    output logic            err_o,
    output logic [AWID-1:0] err_adr_o
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         TW      = AWID - 5;
    localparam logic [4:0] C_DEPTH = 5'(DEPTH);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_LO   = 2'd1;
    localparam logic [1:0] C_HI   = 2'd2;
    localparam logic [1:0] C_GAP  = 2'd3;

    // Queue storage: line address (bits [AWID-1:5]) and PTE image per slot
    logic [TW-1:0]   tag_q [DEPTH];
    logic [255:0]    pte_q [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [4:0]      count_q, count_d;
    logic [1:0]      state_q, state_d;
    logic            err_q, err_d;
    logic [AWID-1:0] err_adr_q, err_adr_d;

    logic            w_inflight;
    logic            w_hit;
    logic [PW-1:0]   w_hit_idx;
    logic            w_acc;
    logic            w_push;
    logic            w_coal;
    logic            w_err;
    logic            w_pop;
    logic            w_unused;

    // Byte offset within the 32-byte PTE line is irrelevant to the queue
    assign w_unused   = ^adr_i[4:0];

    assign w_inflight = (state_q == C_LO) || (state_q == C_HI);

    // Coalesce search: scan from oldest to youngest so the youngest match wins;
    // the head is excluded while its beats are on the bus
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((5'(k) < count_q) &&
                (tag_q[head_q + PW'(k)] == adr_i[AWID-1:5]) &&
                !((k == 0) && w_inflight)) begin
                w_hit     = 1'b1;
                w_hit_idx = head_q + PW'(k);
            end
        end
    end

    assign rdy_o  = (count_q < C_DEPTH) | w_hit;
    assign w_acc  = req_i & rdy_o;
    assign w_push = w_acc & ~w_hit;
    assign w_coal = w_acc & w_hit;
    assign w_err  = w_inflight & err_i;
    assign w_pop  = w_err | ((state_q == C_HI) & ack_i);

    // Queue pointer, occupancy and error-report next-state values
    always_comb begin
        head_d    = head_q + PW'(w_pop);
        tail_d    = tail_q + PW'(w_push);
        count_d   = count_q + 5'(w_push) - 5'(w_pop);
        err_d     = w_err;
        err_adr_d = w_err ? {tag_q[head_q], 5'b0} : err_adr_q;
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= C_IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
        end
    end

    // Slot storage: new entries at the tail, coalesced data into the matched slot
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            tag_q[tail_q] <= adr_i[AWID-1:5];
            pte_q[tail_q] <= pte_i;
        end else if (w_coal) begin
            pte_q[w_hit_idx] <= pte_i;
        end
    end

    // Bus sequencer next state: two beats, then one idle cycle to release the bus
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE: if (count_q != 5'd0) state_d = C_LO;
            C_LO: begin
                if (err_i)      state_d = C_GAP;
                else if (ack_i) state_d = C_HI;
            end
            C_HI:   if (err_i || ack_i) state_d = C_GAP;
            default: state_d = C_IDLE;
        endcase
    end

    // Bus outputs decoded from the sequencer state and the head entry
    always_comb begin
        cyc_o = 1'b0;
        stb_o = 1'b0;
        we_o  = 1'b0;
        sel_o = 16'h0000;
        adr_o = '0;
        dat_o = '0;
        case (state_q)
            C_LO: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = 1'b1;
                sel_o = 16'hFFFF;
                adr_o = {tag_q[head_q], 5'b00000};
                dat_o = pte_q[head_q][127:0];
            end
            C_HI: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = 1'b1;
                sel_o = 16'hFFFF;
                adr_o = {tag_q[head_q], 5'b10000};
                dat_o = pte_q[head_q][255:128];
            end
            default: ;
        endcase
    end

    assign count_o   = count_q;
    assign busy_o    = (count_q != 5'd0) | cyc_o;
    assign err_o     = err_q;
    assign err_adr_o = err_adr_q;

endmodule
`default_nettype wire

// File: tb/tb_thor2022_pte_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thor2022_pte_writeback
//  Description : Directed self-checking bench for the PTE write-back queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thor2022_pte_writeback;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_i;
    logic          rdy_o;
    logic [31:0]   adr_i;
    logic [255:0]  pte_i;
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [15:0]   sel_o;
    logic [31:0]   adr_o;
    logic [127:0]  dat_o;
    logic          ack_i;
    logic          err_i;
    logic          busy_o;
    logic [4:0]    count_o;
    logic          err_o;
    logic [31:0]   err_adr_o;

    int            n_pass  = 0;
    int            n_total = 0;

    logic [31:0]   cap_adr [16];
    logic [127:0]  cap_dat [16];
    int            cap_n;

    thor2022_pte_writeback #(
        .DEPTH (4),
        .AWID  (32)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .rdy_o     (rdy_o),
        .adr_i     (adr_i),
        .pte_i     (pte_i),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .sel_o     (sel_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .ack_i     (ack_i),
        .err_i     (err_i),
        .busy_o    (busy_o),
        .count_o   (count_o),
        .err_o     (err_o),
        .err_adr_o (err_adr_o)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; one accept per rising edge
    task automatic do_push(input logic [31:0] a, input logic [255:0] p);
        req_i = 1'b1;
        adr_i = a;
        pte_i = p;
        @(negedge clk);
        req_i = 1'b0;
    endtask

    // Record every bus beat seen over a window (acks are immediate)
    task automatic capture(input int cycles);
        cap_n = 0;
        for (int c = 0; c < cycles; c++) begin
            if (cyc_o === 1'b1) begin
                if (cap_n < 16) begin
                    cap_adr[cap_n] = adr_o;
                    cap_dat[cap_n] = dat_o;
                end
                cap_n++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = 1'b0; adr_i = '0; pte_i = '0; ack_i = 1'b0; err_i = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if ({cyc_o, stb_o, we_o} !== 3'b000) $display("FAIL reset_ctl got %b exp 000", {cyc_o, stb_o, we_o}); else n_pass++;
        n_total++; if (sel_o !== 16'h0) $display("FAIL reset_sel got %h exp 0", sel_o); else n_pass++;
        n_total++; if (adr_o !== 32'h0) $display("FAIL reset_adr got %h exp 0", adr_o); else n_pass++;
        n_total++; if (dat_o !== 128'h0) $display("FAIL reset_dat got %h exp 0", dat_o); else n_pass++;
        n_total++; if (count_o !== 5'd0) $display("FAIL reset_count got %0d exp 0", count_o); else n_pass++;
        n_total++; if ({busy_o, err_o} !== 2'b00) $display("FAIL reset_busy_err got %b exp 00", {busy_o, err_o}); else n_pass++;
        n_total++; if (err_adr_o !== 32'h0) $display("FAIL reset_err_adr got %h exp 0", err_adr_o); else n_pass++;
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        ack_i = 1'b1;
        do_push(32'h0000_1234, {128'hB, 128'hA});
        n_total++; if ({count_o, cyc_o} !== {5'd1, 1'b0}) $display("FAIL single_queued got cnt=%0d cyc=%b exp cnt=1 cyc=0", count_o, cyc_o); else n_pass++;
        @(negedge clk);
        n_total++; if ({cyc_o, stb_o, we_o, sel_o} !== {3'b111, 16'hFFFF}) $display("FAIL single_lo_ctl got %b %h exp 111 ffff", {cyc_o, stb_o, we_o}, sel_o); else n_pass++;
        n_total++; if ({adr_o, dat_o} !== {32'h0000_1220, 128'hA}) $display("FAIL single_lo got %h/%h exp 00001220/a", adr_o, dat_o); else n_pass++;
        @(negedge clk);
        n_total++; if ({cyc_o, adr_o, dat_o} !== {1'b1, 32'h0000_1230, 128'hB}) $display("FAIL single_hi got %b %h/%h exp 1 00001230/b", cyc_o, adr_o, dat_o); else n_pass++;
        @(negedge clk);
        n_total++; if ({cyc_o, stb_o, we_o, count_o} !== {3'b000, 5'd0}) $display("FAIL single_gap got ctl=%b cnt=%0d exp 000 0", {cyc_o, stb_o, we_o}, count_o); else n_pass++;
        @(negedge clk);
        n_total++; if ({busy_o, cyc_o} !== 2'b00) $display("FAIL single_idle got busy=%b cyc=%b exp 0 0", busy_o, cyc_o); else n_pass++;
        ack_i = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] a;
        logic [31:0] b;
        ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h1000 * (i + 1);
            do_push(a, {96'h0, a + 32'h1, 96'h0, a});
        end
        n_total++; if ({count_o, adr_o} !== {5'd4, 32'h1000}) $display("FAIL full_cnt got %0d/%h exp 4/00001000", count_o, adr_o); else n_pass++;
        req_i = 1'b1; adr_i = 32'h5000; pte_i = {128'h5001, 128'h5000};
        #1;
        n_total++; if (rdy_o !== 1'b0) $display("FAIL full_rdy got %b exp 0", rdy_o); else n_pass++;
        @(negedge clk);
        n_total++; if (count_o !== 5'd4) $display("FAIL full_refuse got %0d exp 4", count_o); else n_pass++;
        ack_i = 1'b1;
        @(negedge clk);
        n_total++; if ({adr_o, count_o} !== {32'h1010, 5'd4}) $display("FAIL full_hi got %h cnt=%0d exp 00001010 4", adr_o, count_o); else n_pass++;
        @(negedge clk);
        n_total++; if (count_o !== 5'd3) $display("FAIL full_pop_refuse got %0d exp 3", count_o); else n_pass++;
        req_i = 1'b0;
        capture(40);
        n_total++; if (cap_n !== 6) $display("FAIL full_beats got %0d exp 6", cap_n); else n_pass++;
        for (int j = 0; j < 6; j++) begin
            b = 32'h2000 + 32'h1000 * (j / 2);
            n_total++;
            if ({cap_adr[j], cap_dat[j]} !== {b + 32'h10 * (j % 2), 96'h0, b + 32'(j % 2)})
                $display("FAIL full_order[%0d] got %h/%h exp %h/%h", j, cap_adr[j], cap_dat[j], b + 32'h10 * (j % 2), b + 32'(j % 2));
            else n_pass++;
        end
        ack_i = 1'b0;
    endtask

    task automatic test_coalesce();
        logic [31:0]  ea [6];
        logic [127:0] ed [6];
        ea = '{32'h100, 32'h110, 32'h200, 32'h210, 32'h100, 32'h110};
        ed = '{128'h11A, 128'h11B, 128'h33A, 128'h33B, 128'h44A, 128'h44B};
        ack_i = 1'b0;
        do_push(32'h100, {128'h11B, 128'h11A});
        do_push(32'h200, {128'h22B, 128'h22A});
        n_total++; if ({cyc_o, adr_o} !== {1'b1, 32'h100}) $display("FAIL coal_inflight got %b %h exp 1 00000100", cyc_o, adr_o); else n_pass++;
        do_push(32'h200, {128'h33B, 128'h33A});
        n_total++; if (count_o !== 5'd2) $display("FAIL coal_merge_cnt got %0d exp 2", count_o); else n_pass++;
        do_push(32'h100, {128'h44B, 128'h44A});
        n_total++; if (count_o !== 5'd3) $display("FAIL coal_head_cnt got %0d exp 3", count_o); else n_pass++;
        ack_i = 1'b1;
        capture(40);
        n_total++; if (cap_n !== 6) $display("FAIL coal_beats got %0d exp 6", cap_n); else n_pass++;
        for (int j = 0; j < 6; j++) begin
            n_total++;
            if ({cap_adr[j], cap_dat[j]} !== {ea[j], ed[j]})
                $display("FAIL coal_beat[%0d] got %h/%h exp %h/%h", j, cap_adr[j], cap_dat[j], ea[j], ed[j]);
            else n_pass++;
        end
        ack_i = 1'b0;
    endtask

    task automatic test_error();
        ack_i = 1'b0; err_i = 1'b0;
        do_push(32'h400, {128'h4B, 128'h4A});
        do_push(32'h500, {128'h5B, 128'h5A});
        n_total++; if (adr_o !== 32'h400) $display("FAIL err_lo got %h exp 00000400", adr_o); else n_pass++;
        ack_i = 1'b1;
        @(negedge clk);
        n_total++; if (adr_o !== 32'h410) $display("FAIL err_hi got %h exp 00000410", adr_o); else n_pass++;
        ack_i = 1'b0; err_i = 1'b1;
        @(negedge clk);
        err_i = 1'b0;
        n_total++; if ({err_o, err_adr_o} !== {1'b1, 32'h400}) $display("FAIL err_pulse got %b %h exp 1 00000400", err_o, err_adr_o); else n_pass++;
        n_total++; if ({cyc_o, count_o} !== {1'b0, 5'd1}) $display("FAIL err_drop got cyc=%b cnt=%0d exp 0 1", cyc_o, count_o); else n_pass++;
        @(negedge clk);
        n_total++; if ({err_o, err_adr_o} !== {1'b0, 32'h400}) $display("FAIL err_one_cycle got %b %h exp 0 00000400", err_o, err_adr_o); else n_pass++;
        @(negedge clk);
        n_total++; if ({cyc_o, adr_o, dat_o} !== {1'b1, 32'h500, 128'h5A}) $display("FAIL err_next got %b %h/%h exp 1 00000500/5a", cyc_o, adr_o, dat_o); else n_pass++;
        ack_i = 1'b1; err_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0; err_i = 1'b0;
        n_total++; if ({err_o, err_adr_o, cyc_o, count_o} !== {1'b1, 32'h500, 1'b0, 5'd0}) $display("FAIL err_wins got err=%b adr=%h cyc=%b cnt=%0d exp 1 00000500 0 0", err_o, err_adr_o, cyc_o, count_o); else n_pass++;
        @(negedge clk);
        n_total++; if (err_o !== 1'b0) $display("FAIL err_clear got %b exp 0", err_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        ack_i = 1'b0;
        do_push(32'h600, {128'h6B, 128'h6A});
        do_push(32'h700, {128'h7B, 128'h7A});
        do_push(32'h800, {128'h8B, 128'h8A});
        n_total++; if ({cyc_o, adr_o, count_o} !== {1'b1, 32'h600, 5'd3}) $display("FAIL rmid_pre got %b %h %0d exp 1 00000600 3", cyc_o, adr_o, count_o); else n_pass++;
        rst_ni = 1'b0;
        @(negedge clk);
        n_total++; if ({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o} !== '0) $display("FAIL rmid_bus got ctl=%b sel=%h adr=%h dat=%h exp all 0", {cyc_o, stb_o, we_o}, sel_o, adr_o, dat_o); else n_pass++;
        n_total++; if ({count_o, busy_o, err_o, err_adr_o} !== '0) $display("FAIL rmid_status got cnt=%0d busy=%b err=%b eadr=%h exp all 0", count_o, busy_o, err_o, err_adr_o); else n_pass++;
        rst_ni = 1'b1;
        @(negedge clk);
        ack_i = 1'b1;
        do_push(32'h0000_1234, {128'hB, 128'hA});
        @(negedge clk);
        n_total++; if ({cyc_o, adr_o, dat_o} !== {1'b1, 32'h0000_1220, 128'hA}) $display("FAIL rmid_lo got %b %h/%h exp 1 00001220/a", cyc_o, adr_o, dat_o); else n_pass++;
        @(negedge clk);
        n_total++; if ({cyc_o, adr_o, dat_o} !== {1'b1, 32'h0000_1230, 128'hB}) $display("FAIL rmid_hi got %b %h/%h exp 1 00001230/b", cyc_o, adr_o, dat_o); else n_pass++;
        @(negedge clk);
        n_total++; if ({cyc_o, count_o} !== {1'b0, 5'd0}) $display("FAIL rmid_done got %b %0d exp 0 0", cyc_o, count_o); else n_pass++;
        @(negedge clk);
        ack_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        ack_i = 1'b0;
        do_push(32'h900, {128'h9B, 128'h9A});
        do_push(32'hA00, {128'hAB, 128'hAA});
        n_total++; if (count_o !== 5'd2) $display("FAIL b2b_cnt got %0d exp 2", count_o); else n_pass++;
        for (int w = 0; w < 3; w++) begin
            if (w == 2) ack_i = 1'b1;
            n_total++; if ({cyc_o, adr_o, dat_o} !== {1'b1, 32'h900, 128'h9A}) $display("FAIL b2b_lo_wait[%0d] got %b %h/%h exp 1 00000900/9a", w, cyc_o, adr_o, dat_o); else n_pass++;
            @(negedge clk);
        end
        ack_i = 1'b0;
        for (int w = 0; w < 2; w++) begin
            n_total++; if ({cyc_o, adr_o, dat_o} !== {1'b1, 32'h910, 128'h9B}) $display("FAIL b2b_hi_wait[%0d] got %b %h/%h exp 1 00000910/9b", w, cyc_o, adr_o, dat_o); else n_pass++;
            if (w == 0) @(negedge clk);
        end
        ack_i = 1'b1;
        req_i = 1'b1; adr_i = 32'hB00; pte_i = {128'hBB, 128'hBA};
        @(negedge clk);
        req_i = 1'b0;
        n_total++; if ({cyc_o, count_o} !== {1'b0, 5'd2}) $display("FAIL b2b_push_pop got cyc=%b cnt=%0d exp 0 2", cyc_o, count_o); else n_pass++;
        capture(40);
        n_total++; if (cap_n !== 4) $display("FAIL b2b_beats got %0d exp 4", cap_n); else n_pass++;
        n_total++; if ({cap_adr[0], cap_dat[0], cap_adr[2], cap_dat[2]} !== {32'hA00, 128'hAA, 32'hB00, 128'hBA}) $display("FAIL b2b_order got %h/%h %h/%h exp 00000a00/aa 00000b00/ba", cap_adr[0], cap_dat[0], cap_adr[2], cap_dat[2]); else n_pass++;
        ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_coalesce();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
